// File: rtl/eth_tx_arbiter_serializer.sv
// Round-robin, frame-granular arbiter of NUM_CHANNELS AXI-Stream sources onto one
// 8-bit MAC TX stream; beats are serialised LSB byte first with tkeep honoured on tlast.
module eth_tx_arbiter_serializer #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int IW = (KEEP_WIDTH > 1) ? $clog2(KEEP_WIDTH) : 1
) (
  input  logic                             gtx_clk,
  input  logic                             gtx_rst_n,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_CHANNELS-1:0]          s_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]          s_axis_tlast,
  input  logic [NUM_CHANNELS-1:0]          s_axis_tuser,
  output logic [NUM_CHANNELS-1:0]          s_axis_tready,
  output logic [7:0]                       m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tuser,
  input  logic                             m_axis_tready,
  output logic [CW-1:0]                    active_channel,
  output logic                             busy,
  output logic [31:0]                      frame_count,
  output logic [31:0]                      byte_count,
  output logic [31:0]                      bad_frame_count
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  logic [CW-1:0]         ptr;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [IW-1:0]         buf_b;
  logic [IW-1:0]         buf_end;
  logic                  buf_valid;
  logic                  buf_last;
  logic                  buf_user;

  logic [DATA_WIDTH-1:0] ch_data [NUM_CHANNELS];
  logic [KEEP_WIDTH-1:0] ch_keep [NUM_CHANNELS];

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_split
    assign ch_data[g] = s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign ch_keep[g] = s_axis_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH];
  end

  // First valid channel strictly after ptr, wrapping around.
  logic [CW-1:0] next_grant;
  logic          any_valid;
  logic [CW:0]   idx;
  always_comb begin
    next_grant = '0;
    any_valid  = 1'b0;
    idx        = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      idx = {1'b0, ptr} + (CW+1)'(i);
      if (idx >= (CW+1)'(NUM_CHANNELS)) idx = idx - (CW+1)'(NUM_CHANNELS);
      if (!any_valid && s_axis_tvalid[idx[CW-1:0]]) begin
        any_valid  = 1'b1;
        next_grant = idx[CW-1:0];
      end
    end
  end

  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  sel_valid, sel_last, sel_user;
  logic [IW-1:0]         keep_end;

  assign sel_data  = ch_data[active_channel];
  assign sel_keep  = ch_keep[active_channel];
  assign sel_valid = s_axis_tvalid[active_channel];
  assign sel_last  = s_axis_tlast[active_channel];
  assign sel_user  = s_axis_tuser[active_channel];

  always_comb begin
    keep_end = '0;
    for (int k = 0; k < KEEP_WIDTH; k++)
      if (sel_keep[k]) keep_end = IW'(k);
  end

  // Valid/ready: a transfer occurs on a rising edge where valid and ready are both
  // high; valid never waits on ready, and ready here may depend combinationally on
  // m_axis_tready so the buffer can refill in the cycle its final byte leaves.
  logic last_byte, m_hs, take_ok, accept, frame_done;
  assign last_byte  = (buf_b == buf_end);
  assign m_hs       = buf_valid && m_axis_tready;
  assign take_ok    = (state == XFER) && (!buf_valid || (m_axis_tready && last_byte && !buf_last));
  assign accept     = take_ok && sel_valid;
  assign frame_done = m_hs && last_byte && buf_last;

  assign s_axis_tready = take_ok ? (NUM_CHANNELS'(1) << active_channel) : '0;
  assign m_axis_tvalid = buf_valid;
  assign m_axis_tdata  = buf_data[{buf_b, 3'b000} +: 8];
  assign m_axis_tlast  = buf_valid && buf_last && last_byte;
  assign m_axis_tuser  = m_axis_tlast && buf_user;
  assign busy          = (state == XFER);

  always_ff @(posedge gtx_clk) begin
    if (!gtx_rst_n) begin
      state           <= IDLE;
      ptr             <= CW'(NUM_CHANNELS - 1);
      active_channel  <= '0;
      buf_data        <= '0;
      buf_b           <= '0;
      buf_end         <= '0;
      buf_valid       <= 1'b0;
      buf_last        <= 1'b0;
      buf_user        <= 1'b0;
      frame_count     <= '0;
      byte_count      <= '0;
      bad_frame_count <= '0;
    end else begin
      if (m_hs) byte_count <= byte_count + 32'd1;
      case (state)
        IDLE: begin
          if (any_valid) begin
            active_channel <= next_grant;
            ptr            <= next_grant;
            state          <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            buf_data  <= sel_data;
            buf_b     <= '0;
            buf_end   <= sel_last ? keep_end : IW'(KEEP_WIDTH - 1);
            buf_last  <= sel_last;
            buf_user  <= sel_last && (sel_user || (sel_keep == '0));
            buf_valid <= 1'b1;
          end else if (m_hs && last_byte) begin
            buf_valid <= 1'b0;
          end else if (m_hs) begin
            buf_b <= buf_b + IW'(1);
          end
          if (frame_done) begin
            state       <= IDLE;
            frame_count <= frame_count + 32'd1;
            if (buf_user) bad_frame_count <= bad_frame_count + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
